// File: rtl/mean_pkg.sv
// mean_pkg: width derivation and rounding-offset helpers shared by the mean stream accumulator
package mean_pkg;
  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction
  function automatic int sumw(input int wid, input int n);
    return wid + $clog2(n);
  endfunction
  function automatic int round_ofs(input int n, input int round);
    return round != 0 ? n / 2 : 0;
  endfunction
endpackage

// File: rtl/mean_stream_acc_if.sv
// mean_stream_acc_if: sample input handshake, result output handshake, clear and fill status
interface mean_stream_acc_if #(parameter int WID = 16, parameter int LOG2N = 7);
  logic clear, in_valid, in_ready, out_valid, out_ready;
  logic [WID-1:0] in_data, out_mean;
  logic [WID+LOG2N-1:0] out_sum;
  logic [LOG2N-1:0] fill_cnt;
  modport master(output clear, in_valid, in_data, out_ready,
                 input in_ready, out_valid, out_mean, out_sum, fill_cnt);
  modport slave(input clear, in_valid, in_data, out_ready,
                output in_ready, out_valid, out_mean, out_sum, fill_cnt);
endinterface

// File: rtl/mean_out_slot.sv
// mean_out_slot: single-entry valid/ready result register; a load wins over a same-cycle drain
module mean_out_slot #(parameter int SUMW = 23, parameter int WID = 16) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic [SUMW-1:0] sum_in,
  input  logic [WID-1:0]  mean_in,
  output logic            valid,
  output logic [SUMW-1:0] sum,
  output logic [WID-1:0]  mean
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      sum <= '0;
      mean <= '0;
    end else if (load) begin
      valid <= 1'b1;
      sum <= sum_in;
      mean <= mean_in;
    end else if (drain) valid <= 1'b0;
endmodule

// File: rtl/mean_stream_acc.sv
// mean_stream_acc: accumulates NUM_INPUTS streamed samples per frame, emits frame sum and mean
module mean_stream_acc
  import mean_pkg::*;
#(parameter int NUM_INPUTS = 128, parameter int WID = 16, parameter int ROUND = 0) (
  input logic clk,
  input logic rst,
  mean_stream_acc_if.slave bus
);
  localparam int LOG2N = log2n(NUM_INPUTS);
  localparam int SUMW = sumw(WID, NUM_INPUTS);
  localparam logic [SUMW-1:0] OFS = SUMW'(round_ofs(NUM_INPUTS, ROUND));
  logic [SUMW-1:0] acc, s, r, out_sum;
  logic [WID-1:0] out_mean;
  logic [LOG2N-1:0] fill;
  logic last, take, done, slot_valid;
  assign last = fill == LOG2N'(NUM_INPUTS - 1);
  // only the frame-completing sample has to wait for a free output slot
  assign bus.in_ready = !bus.clear && (!last || !slot_valid || bus.out_ready);
  assign take = bus.in_valid && bus.in_ready;
  assign done = take && last;
  assign s = acc + SUMW'(bus.in_data);
  assign r = s + OFS;
  assign bus.fill_cnt = fill;
  assign bus.out_valid = slot_valid;
  assign bus.out_sum = out_sum;
  assign bus.out_mean = out_mean;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      fill <= '0;
    end else if (bus.clear || done) begin
      acc <= '0;
      fill <= '0;
    end else if (take) begin
      acc <= s;
      fill <= fill + LOG2N'(1);
    end
  mean_out_slot #(.SUMW(SUMW), .WID(WID)) u_slot (
    .clk(clk),
    .rst(rst),
    .load(done),
    .drain(bus.out_ready),
    .sum_in(s),
    .mean_in(WID'(r >> LOG2N)),
    .valid(slot_valid),
    .sum(out_sum),
    .mean(out_mean)
  );
endmodule

// File: tb/tb_mean_stream_acc.sv
// tb_mean_stream_acc: scoreboard bench driving truncating and rounding instances in lockstep
module tb_mean_stream_acc;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 1;
  logic [15:0] in_data = 0;
  int n_cmp = 0, n_bad = 0, stalls = 0;
  typedef struct packed {logic [22:0] sum; logic [15:0] m0; logic [15:0] m1;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mean_stream_acc_if #(.WID(16), .LOG2N(7)) a(), b();
  assign a.clear = clear;
  assign a.in_valid = in_valid;
  assign a.in_data = in_data;
  assign a.out_ready = out_ready;
  assign b.clear = clear;
  assign b.in_valid = in_valid;
  assign b.in_data = in_data;
  assign b.out_ready = out_ready;

  mean_stream_acc #(.NUM_INPUTS(128), .WID(16), .ROUND(0)) dut0 (.clk(clk), .rst(rst), .bus(a.slave));
  mean_stream_acc #(.NUM_INPUTS(128), .WID(16), .ROUND(1)) dut1 (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic push(input int sum, input int m0, input int m1);
    exp_t e;
    e.sum = 23'(sum);
    e.m0 = 16'(m0);
    e.m1 = 16'(m1);
    q.push_back(e);
  endtask

  task automatic send(input logic [15:0] d);
    int t = 0;
    in_valid = 1;
    in_data = d;
    #1;
    while (!a.in_ready && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    stalls += t;
    if (t == 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic send_n(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) send(d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a.out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got sum %0d expected no output", a.out_sum);
      end else begin
        e = q.pop_front();
        chk("out_sum", a.out_sum, e.sum);
        chk("out_mean", a.out_mean, e.m0);
        chk("out_mean_round", b.out_mean, e.m1);
        chk("round_out_valid", b.out_valid, 1);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_fill_cnt", a.fill_cnt, 0);
    chk("rst_out_sum", a.out_sum, 0);
    chk("rst_out_mean", a.out_mean, 0);
    chk("rst_in_ready", a.in_ready, 1);
    // ramps and saturation, consumer always ready
    for (int i = 0; i < 128; i++) send(16'(i));
    push(8128, 63, 64);
    for (int i = 1; i <= 128; i++) send(16'(i));
    push(8256, 64, 65);
    send_n(16'hFFFF, 128);
    push(32'h7FFF80, 16'hFFFF, 16'hFFFF);
    @(posedge clk);
    #1;
    // backpressure: next frame streams in while result is pending
    out_ready = 0;
    send_n(2, 128);
    push(256, 2, 2);
    stalls = 0;
    send_n(4, 127);
    chk("bp_stalls", stalls, 0);
    chk("bp_held_valid", a.out_valid, 1);
    chk("bp_held_sum", a.out_sum, 256);
    in_valid = 1;
    in_data = 4;
    #1;
    chk("bp_in_ready", a.in_ready, 0);
    chk("bp_fill_cnt", a.fill_cnt, 127);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stable_sum", a.out_sum, 256);
    chk("bp_stable_mean", a.out_mean, 2);
    chk("bp_stable_valid", a.out_valid, 1);
    chk("bp_still_stalled", a.in_ready, 0);
    push(512, 4, 4);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    in_valid = 0;
    chk("bp_no_bubble_valid", a.out_valid, 1);
    chk("bp_new_sum", a.out_sum, 512);
    chk("bp_fill_wrap", a.fill_cnt, 0);
    out_ready = 1;
    @(posedge clk);
    #1;
    // clear discards the partial frame but keeps the pending result
    out_ready = 0;
    send_n(7, 128);
    push(896, 7, 7);
    send_n(9, 50);
    chk("clr_fill_before", a.fill_cnt, 50);
    clear = 1;
    in_valid = 1;
    in_data = 9;
    #1;
    chk("clr_in_ready", a.in_ready, 0);
    @(posedge clk);
    #1;
    clear = 0;
    in_valid = 0;
    chk("clr_fill_after", a.fill_cnt, 0);
    chk("clr_keep_valid", a.out_valid, 1);
    chk("clr_keep_sum", a.out_sum, 896);
    out_ready = 1;
    @(posedge clk);
    #1;
    send_n(5, 128);
    push(640, 5, 5);
    repeat (2) @(posedge clk);
    #1;
    // asynchronous reset with a pending result and a partial frame
    out_ready = 0;
    send_n(1, 128);
    send_n(3, 30);
    chk("ar_pre_fill", a.fill_cnt, 30);
    chk("ar_pre_valid", a.out_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("ar_out_valid", a.out_valid, 0);
    chk("ar_fill_cnt", a.fill_cnt, 0);
    chk("ar_out_sum", a.out_sum, 0);
    chk("ar_out_mean", a.out_mean, 0);
    #2;
    rst = 0;
    @(posedge clk);
    #1;
    out_ready = 1;
    send_n(3, 128);
    push(384, 3, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
